// File: rtl/axi4_traffic_master_if.sv
// AXI4 bus bundle between the traffic master and a slave (five channels).
// A transfer happens on a rising ACLK edge where VALID and READY are both 1; once VALID is raised it and its payload stay stable until that edge.
interface axi4_traffic_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic                  AWVALID;
    logic                  AWREADY;

    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WVALID;
    logic                  WLAST;
    logic                  WREADY;

    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic                  ARVALID;
    logic                  ARREADY;

    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RLAST;
    logic                  RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWVALID, input AWREADY,
        output WDATA, WVALID, WLAST, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, RLAST, output RREADY
    );

    modport slave (
        input AWADDR, AWLEN, AWSIZE, AWVALID, output AWREADY,
        input WDATA, WVALID, WLAST, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARLEN, ARSIZE, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, RLAST, input RREADY
    );
endinterface

// File: rtl/axi4_traffic_master.sv
// Single-burst AXI4 traffic generator: writes seed+beat patterns or reads them back and
// counts mismatching beats, with a per-handshake watchdog that aborts a stalled burst.
module axi4_traffic_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  start,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    output logic                  busy,
    output logic                  done,
    output logic                  resp_err,
    output logic [7:0]            mismatch_cnt,
    output logic [2:0]            state_dbg,
    axi4_traffic_master_if.master axi
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [7:0]            len_q, len_n;
    logic [DATA_WIDTH-1:0] seed_q, seed_n;
    logic [7:0]            beat_q, beat_n;
    logic [7:0]            wdog_q, wdog_n;
    logic                  err_q, err_n;
    logic [7:0]            mm_q, mm_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic                  wlast_q, wlast_n;
    logic                  busy_q, done_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic                  hs, active;
    logic [DATA_WIDTH-1:0] expect_data;

    always_comb begin
        state_n     = state_q;
        addr_n      = addr_q;
        len_n       = len_q;
        seed_n      = seed_q;
        beat_n      = beat_q;
        wdog_n      = wdog_q;
        err_n       = err_q;
        mm_n        = mm_q;
        hs          = 1'b0;
        active      = 1'b0;
        expect_data = seed_q + DATA_WIDTH'(beat_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_n  = cmd_addr;
                    len_n   = cmd_len;
                    seed_n  = cmd_seed;
                    beat_n  = 8'd0;
                    wdog_n  = 8'd0;
                    err_n   = 1'b0;
                    mm_n    = 8'd0;
                    state_n = cmd_write ? S_AW : S_AR;
                end
            end
            S_AW: begin
                active = 1'b1;
                if (awvalid_q && axi.AWREADY) begin
                    hs      = 1'b1;
                    beat_n  = 8'd0;
                    state_n = S_W;
                end
            end
            S_W: begin
                active = 1'b1;
                if (wvalid_q && axi.WREADY) begin
                    hs     = 1'b1;
                    beat_n = beat_q + 8'd1;
                    if (beat_q == len_q) state_n = S_B;
                end
            end
            S_B: begin
                active = 1'b1;
                if (bready_q && axi.BVALID) begin
                    hs      = 1'b1;
                    err_n   = err_q | (axi.BRESP != 2'b00);
                    state_n = S_DONE;
                end
            end
            S_AR: begin
                active = 1'b1;
                if (arvalid_q && axi.ARREADY) begin
                    hs      = 1'b1;
                    beat_n  = 8'd0;
                    state_n = S_R;
                end
            end
            S_R: begin
                active = 1'b1;
                if (rready_q && axi.RVALID) begin
                    hs     = 1'b1;
                    beat_n = beat_q + 8'd1;
                    // An error beat carries no meaningful data, so it is not compared.
                    if (axi.RRESP != 2'b00) begin
                        err_n = 1'b1;
                    end else if ((axi.RDATA != expect_data) && (mm_q != 8'hFF)) begin
                        mm_n = mm_q + 8'd1;
                    end
                    if (axi.RLAST || (beat_q == len_q)) state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Watchdog aborts on the edge where the stall count would reach 255.
        if (active) begin
            if (hs) begin
                wdog_n = 8'd0;
            end else if (wdog_q == 8'hFE) begin
                wdog_n  = 8'hFF;
                err_n   = 1'b1;
                state_n = S_DONE;
            end else begin
                wdog_n = wdog_q + 8'd1;
            end
        end

        wdata_n = seed_n + DATA_WIDTH'(beat_n);
        wlast_n = (state_n == S_W) && (beat_n == len_n);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            seed_q    <= '0;
            beat_q    <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
            mm_q      <= '0;
            wdata_q   <= '0;
            wlast_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_n;
            addr_q    <= addr_n;
            len_q     <= len_n;
            seed_q    <= seed_n;
            beat_q    <= beat_n;
            wdog_q    <= wdog_n;
            err_q     <= err_n;
            mm_q      <= mm_n;
            wdata_q   <= wdata_n;
            wlast_q   <= wlast_n;
            busy_q    <= (state_n != S_IDLE);
            done_q    <= (state_n == S_DONE);
            awvalid_q <= (state_n == S_AW);
            wvalid_q  <= (state_n == S_W);
            bready_q  <= (state_n == S_B);
            arvalid_q <= (state_n == S_AR);
            rready_q  <= (state_n == S_R);
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign resp_err     = err_q;
    assign mismatch_cnt = mm_q;
    assign state_dbg    = state_q;

    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = len_q;
    assign axi.AWSIZE  = 3'b010;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.WLAST   = wlast_q;
    assign axi.BREADY  = bready_q;
    assign axi.ARADDR  = addr_q;
    assign axi.ARLEN   = len_q;
    assign axi.ARSIZE  = 3'b010;
    assign axi.ARVALID = arvalid_q;
    assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_traffic_master.sv
// Bench for axi4_traffic_master: a reactive AXI slave, a directed vector table, random
// commands checked against a burst-level reference model, and reset corner sequences.
module tb_axi4_traffic_master;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int MAX_CYC = 3000;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          start = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [DW-1:0] cmd_seed = '0;
  logic          busy, done, resp_err;
  logic [7:0]    mismatch_cnt;
  logic [2:0]    state_dbg;

  axi4_traffic_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi4_traffic_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .busy(busy), .done(done), .resp_err(resp_err), .mismatch_cnt(mismatch_cnt),
    .state_dbg(state_dbg), .axi(bus)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  typedef struct {
    bit         wr;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [31:0] seed;
    logic [1:0]  resp;
    int          bad_beat;   // -1 none, -2 every beat, else beat index
    int          early_last; // -1 none, else beat index carrying RLAST
    int          stall;      // cycles of withheld WREADY / RVALID at the data phase
    bit          restart;
    bit          lazy;
    bit          exp_err;
    logic [7:0]  exp_mm;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic slave_idle();
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = 2'b00;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = 2'b00; bus.RLAST = 1'b0;
  endtask

  // Burst-level reference: outcome follows from beat counts and response codes only.
  function automatic void model(input vec_t v, output bit e, output logic [7:0] mm);
    int beats, bad;
    bad = 0;
    if (v.stall >= 255) begin
      e = 1'b1;
    end else if (v.wr) begin
      e = (v.resp != 2'b00);
    end else begin
      beats = (v.early_last >= 0 && v.early_last < int'(v.len)) ? v.early_last + 1 : int'(v.len) + 1;
      e = (v.resp != 2'b00);
      if (v.resp == 2'b00) begin
        if (v.bad_beat == -2) bad = beats;
        else if (v.bad_beat >= 0 && v.bad_beat < beats) bad = 1;
      end
    end
    mm = (bad > 255) ? 8'd255 : 8'(bad);
  endfunction

  function automatic logic [DW-1:0] rdata_for(input vec_t v, input int i);
    logic [DW-1:0] d;
    d = v.seed + DW'(i);
    if (v.bad_beat == -2 || v.bad_beat == i) d = d ^ 32'h5A5A_0F0F;
    return d;
  endfunction

  // driver + reactive slave for one command
  task automatic do_cmd(input vec_t v, output int w_stalls);
    int stall_left, rbeat, wbeats, last_idx, nbeats, cyc;
    bit aw_seen, ar_seen, b_done, w_early, b_hs, r_hs;
    logic [DW-1:0] e;
    stall_left = v.stall; rbeat = 0; wbeats = 0; w_stalls = 0;
    aw_seen = 0; ar_seen = 0; b_done = 0; w_early = 0; b_hs = 0; r_hs = 0;
    nbeats = int'(v.len) + 1;
    last_idx = (v.early_last >= 0 && v.early_last < int'(v.len)) ? v.early_last : int'(v.len);
    exp_q.delete();
    if (v.wr) for (int i = 0; i < nbeats; i++) exp_q.push_back(v.seed + DW'(i));

    @(negedge ACLK);
    start = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len; cmd_seed = v.seed;
    @(negedge ACLK);
    start = 1'b0;
    cmd_addr = AW'($urandom); cmd_len = 8'($urandom); cmd_seed = $urandom;
    check("busy_after_start", busy, 1);

    for (cyc = 0; cyc < MAX_CYC; cyc++) begin
      if (done) break;
      start = (v.restart && cyc == 1);
      cmd_write = start ? ~v.wr : v.wr;
      if (bus.WVALID && !aw_seen) w_early = 1;
      if (b_hs) begin bus.BVALID = 1'b0; b_hs = 0; end
      if (r_hs) begin bus.RVALID = 1'b0; r_hs = 0; end

      bus.AWREADY = v.lazy ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.ARREADY = v.lazy ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (v.wr && stall_left > 0) begin
        bus.WREADY = 1'b0;
        if (bus.WVALID) stall_left--;
      end else begin
        bus.WREADY = v.lazy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (bus.WVALID && !bus.WREADY) w_stalls++;
      if (!bus.BVALID && !b_done && wbeats == nbeats && (!v.lazy || $urandom_range(0, 1) == 1)) begin
        bus.BVALID = 1'b1; bus.BRESP = v.resp;
      end
      if (ar_seen && rbeat <= last_idx) begin
        if (stall_left > 0) begin
          bus.RVALID = 1'b0; stall_left--;
        end else begin
          if (!bus.RVALID) bus.RVALID = v.lazy ? ($urandom_range(0, 2) != 0) : 1'b1;
          bus.RDATA = rdata_for(v, rbeat); bus.RRESP = v.resp; bus.RLAST = (rbeat == last_idx);
        end
      end else begin
        bus.RVALID = 1'b0;
      end

      // transfers that happen on the coming edge
      if (bus.AWVALID && bus.AWREADY) begin
        check("awaddr", bus.AWADDR, v.addr);
        check("awlen", bus.AWLEN, v.len);
        check("awsize", bus.AWSIZE, 3'b010);
        aw_seen = 1;
      end
      if (bus.WVALID && bus.WREADY) begin
        wbeats++;
        if (exp_q.size() == 0) begin
          check("w_extra_beat", wbeats, nbeats);
        end else begin
          e = exp_q.pop_front();
          check("wdata", bus.WDATA, e);
          check("wlast", bus.WLAST, exp_q.size() == 0);
        end
      end
      if (bus.BVALID && bus.BREADY) begin b_hs = 1; b_done = 1; end
      if (bus.ARVALID && bus.ARREADY) begin
        check("araddr", bus.ARADDR, v.addr);
        check("arlen", bus.ARLEN, v.len);
        check("arsize", bus.ARSIZE, 3'b010);
        ar_seen = 1;
      end
      if (bus.RVALID && bus.RREADY) begin rbeat++; r_hs = 1; end
      @(negedge ACLK);
    end
    start = 1'b0;
    check("cmd_completed", cyc < MAX_CYC, 1);
    check("w_before_aw", w_early, 0);
    if (v.wr && v.stall < 255) check("w_all_beats", exp_q.size(), 0);
    slave_idle();
    @(negedge ACLK);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("valids_idle", {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}, 0);
  endtask

  initial begin
    int ws;
    bit e_err;
    logic [7:0] e_mm;
    vec_t v;

    //          wr addr     len    seed          resp  bad early stall rst lazy err mm
    tbl[0]  = '{1, 16'h0010, 8'd3,   32'h100,       2'b00, -1, -1, 0,   0, 0, 0, 8'd0};
    tbl[1]  = '{0, 16'h0010, 8'd3,   32'h100,       2'b00, -1, -1, 0,   0, 0, 0, 8'd0};
    tbl[2]  = '{0, 16'h0010, 8'd3,   32'h100,       2'b00,  2, -1, 0,   0, 1, 0, 8'd1};
    tbl[3]  = '{1, 16'h1000, 8'd1,   32'h55,        2'b10, -1, -1, 0,   0, 1, 1, 8'd0};
    tbl[4]  = '{1, 16'h0200, 8'd3,   32'h7,         2'b00, -1, -1, 300, 0, 1, 1, 8'd0};
    tbl[5]  = '{0, 16'h0300, 8'd2,   32'h9000,      2'b10,  1, -1, 0,   0, 1, 1, 8'd0};
    tbl[6]  = '{0, 16'h0400, 8'd7,   32'h1234,      2'b00,  5,  3, 0,   0, 1, 0, 8'd0};
    tbl[7]  = '{0, 16'h0500, 8'd255, 32'hABCD0000,  2'b00, -2, -1, 0,   0, 1, 0, 8'd255};
    tbl[8]  = '{1, 16'h0600, 8'd0,   32'hFFFFFFFF,  2'b00, -1, -1, 0,   0, 0, 0, 8'd0};
    tbl[9]  = '{1, 16'h0700, 8'd2,   32'hFFFFFFFE,  2'b00, -1, -1, 0,   1, 1, 0, 8'd0};
    tbl[10] = '{0, 16'h0800, 8'd4,   32'h42,        2'b00, -1, -1, 300, 0, 1, 1, 8'd0};
    tbl[11] = '{0, 16'h0900, 8'd0,   32'h0,         2'b00, -1, -1, 0,   1, 0, 0, 8'd0};

    slave_idle();
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_mismatch", mismatch_cnt, 0);
    check("rst_valids", {bus.AWVALID, bus.WVALID, bus.WLAST, bus.BREADY, bus.ARVALID, bus.RREADY}, 0);
    check("rst_addr_data", {bus.AWADDR, bus.ARADDR, bus.WDATA}, 0);
    check("rst_state", state_dbg, 0);
    check("rst_awsize", bus.AWSIZE, 3'b010);
    ARESETn = 1'b1;

    foreach (tbl[i]) begin
      do_cmd(tbl[i], ws);
      check($sformatf("tbl%0d_resp_err", i), resp_err, tbl[i].exp_err);
      check($sformatf("tbl%0d_mismatch", i), mismatch_cnt, tbl[i].exp_mm);
      if (tbl[i].wr && tbl[i].stall >= 255) check("wdog_stalled_cycles", ws, 255);
    end

    for (int n = 0; n < 30; n++) begin
      v.wr = 1'($urandom);
      v.addr = 16'($urandom);
      v.len = 8'($urandom_range(0, 15));
      v.seed = $urandom;
      v.resp = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      v.bad_beat = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 15));
      v.early_last = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
      v.stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
      v.restart = 1'($urandom);
      v.lazy = 1'b1;
      model(v, e_err, e_mm);
      v.exp_err = e_err; v.exp_mm = e_mm;
      do_cmd(v, ws);
      check($sformatf("rnd%0d_resp_err", n), resp_err, v.exp_err);
      check($sformatf("rnd%0d_mismatch", n), mismatch_cnt, v.exp_mm);
    end

    // reset in the middle of a write burst
    @(negedge ACLK);
    start = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0020; cmd_len = 8'd7; cmd_seed = 32'h7;
    bus.AWREADY = 1'b1; bus.WREADY = 1'b0;
    @(negedge ACLK);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.WVALID) break;
      @(negedge ACLK);
    end
    check("mid_w_wvalid", bus.WVALID, 1);
    ARESETn = 1'b0;
    @(negedge ACLK);
    check("mid_w_rst_wvalid", bus.WVALID, 0);
    check("mid_w_rst_busy", busy, 0);
    check("mid_w_rst_addr", bus.AWADDR, 0);
    slave_idle();

    // start together with reset release is taken on that first edge
    ARESETn = 1'b1; start = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0ABC; cmd_len = 8'd2;
    @(negedge ACLK);
    start = 1'b0;
    check("first_edge_busy", busy, 1);
    check("first_edge_arvalid", bus.ARVALID, 1);
    check("first_edge_araddr", bus.ARADDR, 16'h0ABC);
    ARESETn = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
